// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller: time-shares one external
// combinational 4x4 core over four cycles and returns the 16-bit product.
module mult8_seq_ctrl #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [15:0]      done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [7:0]         a_r;
    logic [7:0]         b_r;
    logic [TAG_W-1:0]   tag_r;
    logic [15:0]        acc;
    logic [1:0]         step;
    logic [15:0]        part;
    logic [15:0]        sum;
    logic               accept;
    logic               retire;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        mul_a    = '0;
        mul_b    = '0;
        part     = '0;
        accept   = 1'b0;
        retire   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                // Nibble pair and alignment of the partial product per step.
                case (step)
                    2'd0: begin mul_a = a_r[3:0]; mul_b = b_r[3:0]; part = {8'h00, mul_p};       end
                    2'd1: begin mul_a = a_r[3:0]; mul_b = b_r[7:4]; part = {4'h0, mul_p, 4'h0};  end
                    2'd2: begin mul_a = a_r[7:4]; mul_b = b_r[3:0]; part = {4'h0, mul_p, 4'h0};  end
                    2'd3: begin mul_a = a_r[7:4]; mul_b = b_r[7:4]; part = {mul_p, 8'h00};       end
                    default: ;
                endcase
                if (step == 2'd3) state_nx = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    retire   = 1'b1;
                    accept   = in_valid;
                    state_nx = in_valid ? RUN : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sum = acc + part;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            tag_r     <= '0;
            acc       <= '0;
            step      <= '0;
            out_p     <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
            done_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (retire) begin
                out_valid <= 1'b0;
                done_cnt  <= done_cnt + 16'd1;
            end
            if (accept) begin
                a_r   <= in_a;
                b_r   <= in_b;
                tag_r <= in_tag;
                acc   <= '0;
                step  <= '0;
            end else if (state == RUN) begin
                acc  <= sum;
                step <= step + 2'd1;
                if (step == 2'd3) begin
                    out_p     <= sum;
                    out_tag   <= tag_r;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed and random checks of mult8_seq_ctrl with an exact 4x4 core model.
module tb_mult8_seq_ctrl;

    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [3:0]       mul_a;
    logic [3:0]       mul_b;
    logic [7:0]       mul_p;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_p;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic [15:0]      done_cnt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    // Exact combinational 4x4 core.
    assign mul_p = {4'h0, mul_a} * {4'h0, mul_b};

    mult8_seq_ctrl #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] t);
        bit ok = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_tag   = TAG_W'($urandom);
        check("accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic get_result(input string name, input logic [15:0] ep, input logic [TAG_W-1:0] et,
                              input bit stall);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                check({name, "_p"}, {16'd0, out_p}, {16'd0, ep});
                check({name, "_tag"}, 32'(out_tag), 32'(et));
                got = 1'b1;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check({name, "_done"}, {31'd0, got}, 32'd1);
    endtask

    logic [7:0]       ta [3];
    logic [7:0]       tb [3];
    logic [15:0]      d0;
    logic [7:0]       ra;
    logic [7:0]       rb;
    int unsigned      hs;

    initial begin
        // Reset: in_valid held high must not cause a capture.
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
        check("rst_mul", {24'd0, mul_a, mul_b}, 32'd0);
        check("rst_out_p", {16'd0, out_p}, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        // Directed 0x12 * 0x34 with step-by-step core drive.
        issue(8'h12, 8'h34, 4'h5);
        check("s0_mul", {24'd0, mul_a, mul_b}, 32'h24);
        check("s0_busy", {31'd0, busy}, 32'd1);
        check("s0_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("s1_mul", {24'd0, mul_a, mul_b}, 32'h23);
        @(negedge clk);
        check("s2_mul", {24'd0, mul_a, mul_b}, 32'h14);
        @(negedge clk);
        check("s3_mul", {24'd0, mul_a, mul_b}, 32'h13);
        check("s3_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_out_p", {16'd0, out_p}, 32'h03A8);
        check("lat_out_tag", 32'(out_tag), 32'h5);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_mul", {24'd0, mul_a, mul_b}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_valid", {31'd0, out_valid}, 32'd0);
        check("retire_cnt", {16'd0, done_cnt}, 32'd1);

        // Corners.
        issue(8'hFF, 8'hFF, 4'h3);
        get_result("ffxff", 16'hFE01, 4'h3, 1'b0);
        issue(8'h00, 8'hA5, 4'hA);
        get_result("zero", 16'h0000, 4'hA, 1'b0);

        // Backpressure with a pending request.
        out_ready = 1'b0;
        issue(8'h0B, 8'h0D, 4'h1);
        in_valid = 1'b1; in_a = 8'h21; in_b = 8'h03; in_tag = 4'h2;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        d0 = done_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_p", {16'd0, out_p}, 32'h008F);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_cnt", {16'd0, done_cnt}, {16'd0, d0});
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        check("bp_same_edge_busy", {31'd0, busy}, 32'd1);
        check("bp_same_edge_mul", {24'd0, mul_a, mul_b}, 32'h13);
        check("bp_same_edge_cnt", {16'd0, done_cnt}, {16'd0, d0 + 16'd1});
        check("bp_same_edge_valid", {31'd0, out_valid}, 32'd0);
        get_result("bp_next", 16'h0063, 4'h2, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        begin
            int unsigned idx_in = 0, idx_out = 0, last = 0;
            bit pending = 1'b0;
            ta[0] = 8'h03; tb[0] = 8'h05;
            ta[1] = 8'h10; tb[1] = 8'h10;
            ta[2] = 8'hC8; tb[2] = 8'h02;
            d0 = done_cnt;
            out_ready = 1'b1; in_valid = 1'b1;
            in_a = ta[0]; in_b = tb[0]; in_tag = 4'h0;
            for (int unsigned cyc = 0; cyc < 60 && idx_out < 3; cyc++) begin
                if (pending) begin
                    pending = 1'b0;
                    idx_in++;
                    if (idx_in < 3) begin
                        in_a = ta[idx_in]; in_b = tb[idx_in]; in_tag = TAG_W'(idx_in);
                    end else in_valid = 1'b0;
                end
                #1;
                if (out_valid) begin
                    check("b2b_p", {16'd0, out_p}, 32'({8'd0, ta[idx_out]} * {8'd0, tb[idx_out]}));
                    check("b2b_tag", 32'(out_tag), idx_out);
                    if (idx_out > 0) check("b2b_gap", cyc - last, 32'd5);
                    last = cyc;
                    idx_out++;
                end
                if (in_valid && in_ready) pending = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b0; out_ready = 1'b0;
            check("b2b_count", idx_out, 32'd3);
            check("b2b_cnt", {16'd0, done_cnt}, {16'd0, d0 + 16'd3});
        end

        // Reset in step 2.
        d0 = done_cnt;
        issue(8'h56, 8'h78, 4'h4);
        @(negedge clk);
        @(negedge clk);
        check("mid_s2_mul", {24'd0, mul_a, mul_b}, 32'h58);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_mul", {24'd0, mul_a, mul_b}, 32'd0);
        check("mid_rst_cnt", {16'd0, done_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(8'h07, 8'h09, 4'h6);
        get_result("after_rst", 16'h003F, 4'h6, 1'b0);

        // Random sweep with output stalls.
        d0 = done_cnt;
        hs = 0;
        for (int unsigned n = 0; n < 2000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue(ra, rb, TAG_W'(n));
            get_result("rand", {8'd0, ra} * {8'd0, rb}, TAG_W'(n), 1'b1);
            hs++;
        end
        check("rand_cnt", {16'd0, done_cnt}, 32'(d0 + 16'(hs)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
